heap_cmd_ctrl: RTL and testbench

HEAP_CMD_CTRL -- requirements
Module: heap_cmd_ctrl

---
 rtl/heap_pkg.sv | 51 +++++
 rtl/heap_cmd_ctrl_if.sv | 36 +++
 rtl/heap_cmd_fifo.sv | 49 ++++
 rtl/heap_cmd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_heap_cmd_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap command controller: command/mode codes,
// FSM state encodings, heap geometry and the command-legality helper.
package heap_pkg;

  localparam int IDX_W  = 4;
  localparam int KEY_W  = 8;
  localparam int CMD_W  = 3;
  localparam int MODE_W = 3;

  localparam logic [IDX_W-1:0] HEAP_MAX = 4'd15;

  // Command codes double as the active_mode encoding driven to the index mux.
  typedef enum logic [CMD_W-1:0] {
    CMD_BUILD    = 3'd0,
    CMD_EXTRACT  = 3'd1,
    CMD_INCREASE = 3'd2,
    CMD_INSERT   = 3'd3,
    CMD_WRITE    = 3'd4
  } heap_cmd_e;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MH_START = 3'd1;
  localparam logic [2:0] ST_MH_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXT_COPY = 3'd3;
  localparam logic [2:0] ST_IV_START = 3'd4;
  localparam logic [2:0] ST_IV_WAIT  = 3'd5;
  localparam logic [2:0] ST_WR_RUN   = 3'd6;
  localparam logic [2:0] ST_FINISH   = 3'd7;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [IDX_W-1:0] idx;
    logic [KEY_W-1:0] val;
  } cmd_entry_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] c,
                                        input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] size);
    logic ok;
    ok = 1'b0;
    case (c)
      CMD_BUILD, CMD_WRITE: ok = 1'b1;
      CMD_EXTRACT:          ok = (size != 4'd0);
      CMD_INCREASE:         ok = (idx != 4'd0) && (idx <= size);
      CMD_INSERT:           ok = (size != HEAP_MAX);
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/heap_cmd_ctrl_if.sv
// Command, loader, engine-handshake and status bus of the heap command controller.
interface heap_cmd_ctrl_if;
  import heap_pkg::*;

  logic                  cmd_valid;
  logic [CMD_W-1:0]      cmd;
  logic                  cmd_ready;
  logic [IDX_W-1:0]      cmd_idx;
  logic [KEY_W-1:0]      cmd_val;
  logic                  load_valid;
  logic [MODE_W-1:0]     active_mode;
  logic                  eng_start;
  logic                  eng_done;
  logic [IDX_W-1:0]      mh_root;
  logic [IDX_W-1:0]      iv_idx;
  logic [KEY_W-1:0]      iv_val;
  logic [IDX_W-1:0]      heap_size;
  logic                  ext_copy;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_valid;
  logic                  done;
  logic                  err;

  modport slave (
    input  cmd_valid, cmd, cmd_idx, cmd_val, load_valid, eng_done,
    output cmd_ready, active_mode, eng_start, mh_root, iv_idx, iv_val,
           heap_size, ext_copy, wr_idx, wr_valid, done, err
  );

  modport master (
    output cmd_valid, cmd, cmd_idx, cmd_val, load_valid, eng_done,
    input  cmd_ready, active_mode, eng_start, mh_root, iv_idx, iv_val,
           heap_size, ext_copy, wr_idx, wr_valid, done, err
  );

endinterface

// File: rtl/heap_cmd_fifo.sv
// Two-entry command FIFO used only when HEAP_CMD_FIFO_EN is defined;
// reset flushes it.
module heap_cmd_fifo
  import heap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  cmd_entry_t push_data,
  input  logic       pop,
  output cmd_entry_t pop_data,
  output logic       full,
  output logic       empty
);

  cmd_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/heap_cmd_ctrl.sv
// Heap command sequencer: build, extract-max, increase, insert and write-out.
// Defining HEAP_CMD_FIFO_EN adds a 2-entry command FIFO (heap_cmd_fifo).
module heap_cmd_ctrl
  import heap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  heap_cmd_ctrl_if.slave bus
);

  logic [2:0]        state;
  logic [MODE_W-1:0] active_mode_q;
  logic [IDX_W-1:0]  mh_root_q;
  logic [IDX_W-1:0]  iv_idx_q;
  logic [KEY_W-1:0]  iv_val_q;
  logic [IDX_W-1:0]  heap_size_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic              err_q;

  logic              cur_valid;
  logic [CMD_W-1:0]  cur_cmd;
  logic [IDX_W-1:0]  cur_idx;
  logic [KEY_W-1:0]  cur_val;
  logic              load_ok;
  logic              accept;
  logic              legal;

`ifdef HEAP_CMD_FIFO_EN
  cmd_entry_t push_entry;
  cmd_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;

  assign push_entry = '{cmd: bus.cmd, idx: bus.cmd_idx, val: bus.cmd_val};

  heap_cmd_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.cmd_valid && bus.cmd_ready),
    .push_data (push_entry),
    .pop       (accept),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cmd_ready = !reset && !fifo_full;
  assign cur_valid     = !fifo_empty;
  assign cur_cmd       = head.cmd;
  assign cur_idx       = head.idx;
  assign cur_val       = head.val;
  assign load_ok       = bus.load_valid && fifo_empty;
`else
  assign bus.cmd_ready = !reset && (state == ST_IDLE);
  assign cur_valid     = bus.cmd_valid;
  assign cur_cmd       = bus.cmd;
  assign cur_idx       = bus.cmd_idx;
  assign cur_val       = bus.cmd_val;
  assign load_ok       = bus.load_valid;
`endif

  assign accept = cur_valid && (state == ST_IDLE) && !reset;
  assign legal  = cmd_is_legal(cur_cmd, cur_idx, heap_size_q);

  // A load arriving in the same cycle as an accepted command is dropped so
  // heap_size only ever has one writer per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      active_mode_q <= '0;
      mh_root_q     <= '0;
      iv_idx_q      <= '0;
      iv_val_q      <= '0;
      heap_size_q   <= '0;
      wr_idx_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!legal) begin
              err_q <= 1'b1;
            end else begin
              active_mode_q <= cur_cmd;
              case (cur_cmd)
                CMD_BUILD: begin
                  mh_root_q <= heap_size_q >> 1;
                  state     <= (heap_size_q < 4'd2) ? ST_FINISH : ST_MH_START;
                end
                CMD_EXTRACT: begin
                  heap_size_q <= heap_size_q - 4'd1;
                  mh_root_q   <= 4'd1;
                  state       <= ST_EXT_COPY;
                end
                CMD_INCREASE: begin
                  iv_idx_q <= cur_idx;
                  iv_val_q <= cur_val;
                  state    <= ST_IV_START;
                end
                CMD_INSERT: begin
                  heap_size_q <= heap_size_q + 4'd1;
                  iv_idx_q    <= heap_size_q + 4'd1;
                  iv_val_q    <= cur_val;
                  state       <= ST_IV_START;
                end
                CMD_WRITE: begin
                  if (heap_size_q == 4'd0) begin
                    state <= ST_FINISH;
                  end else begin
                    wr_idx_q <= 4'd1;
                    state    <= ST_WR_RUN;
                  end
                end
                default: state <= ST_IDLE;
              endcase
            end
          end else if (load_ok && (heap_size_q < HEAP_MAX)) begin
            heap_size_q <= heap_size_q + 4'd1;
          end
        end
        ST_MH_START: state <= ST_MH_WAIT;
        ST_MH_WAIT: begin
          if (bus.eng_done) begin
            if (mh_root_q == 4'd1) begin
              state <= ST_FINISH;
            end else begin
              mh_root_q <= mh_root_q - 4'd1;
              state     <= ST_MH_START;
            end
          end
        end
        ST_EXT_COPY: state <= ST_MH_START;
        ST_IV_START: state <= ST_IV_WAIT;
        ST_IV_WAIT: begin
          if (bus.eng_done) state <= ST_FINISH;
        end
        ST_WR_RUN: begin
          if (wr_idx_q == heap_size_q) state <= ST_FINISH;
          else                         wr_idx_q <= wr_idx_q + 4'd1;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are decoded from state and forced low while reset is asserted.
  assign bus.eng_start   = !reset && ((state == ST_MH_START) || (state == ST_IV_START));
  assign bus.ext_copy    = !reset && (state == ST_EXT_COPY);
  assign bus.wr_valid    = !reset && (state == ST_WR_RUN);
  assign bus.done        = !reset && (state == ST_FINISH);
  assign bus.err         = !reset && err_q;

  assign bus.active_mode = active_mode_q;
  assign bus.mh_root     = mh_root_q;
  assign bus.iv_idx      = iv_idx_q;
  assign bus.iv_val      = iv_val_q;
  assign bus.heap_size   = heap_size_q;
  assign bus.wr_idx      = wr_idx_q;

endmodule

// File: tb/tb_heap_cmd_ctrl.sv
// Directed self-checking bench for heap_cmd_ctrl; expected values are hand-computed.
module tb_heap_cmd_ctrl;
  import heap_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  heap_cmd_ctrl_if bus ();

  heap_cmd_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] c,
                                input logic [3:0] idx, input logic [7:0] val);
    bus.cmd_valid = v;
    bus.cmd       = c;
    bus.cmd_idx   = idx;
    bus.cmd_val   = val;
  endtask

  // Present one command for a single edge; returns in the cycle after accept.
  task automatic send(input logic [2:0] c, input logic [3:0] idx, input logic [7:0] val);
    apply_stimulus(1'b1, c, idx, val);
    tick();
    apply_stimulus(1'b0, 3'd0, 4'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_n(input int n);
    bus.load_valid = 1'b1;
    repeat (n) tick();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.load_valid = 1'b0;
    bus.eng_done   = 1'b0;
    apply_stimulus(1'b0, 3'd0, 4'd0, 8'd0);
    tick();
    $display("[TB] reset checks");
    check_output("rst_cmd_ready", bus.cmd_ready, 0);
    check_output("rst_heap_size", bus.heap_size, 0);
    check_output("rst_active_mode", bus.active_mode, 0);
    check_output("rst_mh_root", bus.mh_root, 0);
    check_output("rst_iv_idx", bus.iv_idx, 0);
    check_output("rst_wr_idx", bus.wr_idx, 0);
    check_output("rst_done", bus.done, 0);
    reset = 1'b0;
    tick();
    check_output("idle_cmd_ready", bus.cmd_ready, 1);

`ifdef HEAP_CMD_FIFO_EN
    begin
      logic [2:0] q_cmd [4];
      logic [3:0] q_idx [4];
      logic [2:0] modes [4];
      int  qi;
      int  ndone;
      logic hs;
      logic prev_start;
      q_cmd = '{3'd0, 3'd4, 3'd1, 3'd2};
      q_idx = '{4'd0, 4'd0, 4'd0, 4'd1};
      modes = '{3'd7, 3'd7, 3'd7, 3'd7};
      qi = 0;
      ndone = 0;
      prev_start = 1'b0;
      $display("[TB] fifo back-to-back commands");
      load_n(6);
      check_output("fifo_load_heap_size", bus.heap_size, 6);
      apply_stimulus(1'b1, q_cmd[0], q_idx[0], 8'h55);
      for (int c = 0; c < 400; c++) begin
        if (ndone >= 4) break;
        bus.eng_done = prev_start;
        prev_start   = bus.eng_start;
        if (bus.done) begin
          modes[ndone] = bus.active_mode;
          ndone++;
        end
        hs = bus.cmd_valid && bus.cmd_ready;
        tick();
        if (hs) begin
          if (qi == 2) check_output("fifo_full_ready", bus.cmd_ready, 0);
          qi++;
          if (qi < 4) apply_stimulus(1'b1, q_cmd[qi], q_idx[qi], 8'h55);
          else        apply_stimulus(1'b0, 3'd0, 4'd0, 8'd0);
        end
      end
      bus.eng_done = 1'b0;
      check_output("fifo_done_count", ndone, 4);
      check_output("fifo_order0", modes[0], 0);
      check_output("fifo_order1", modes[1], 4);
      check_output("fifo_order2", modes[2], 1);
      check_output("fifo_order3", modes[3], 2);
      check_output("fifo_final_heap", bus.heap_size, 5);
    end
`else
    $display("[TB] build over 6 elements");
    load_n(6);
    check_output("load6_heap_size", bus.heap_size, 6);
    send(3'd0, 4'd0, 8'd0);
    check_output("build_mode", bus.active_mode, 0);
    for (int r = 3; r >= 1; r--) begin
      check_output("build_eng_start", bus.eng_start, 1);
      check_output("build_mh_root", bus.mh_root, r);
      tick();
      check_output("build_wait_no_start", bus.eng_start, 0);
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
    end
    check_output("build_done", bus.done, 1);
    tick();
    check_output("build_done_cleared", bus.done, 0);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check_output("idle_eng_done_ignored", bus.done, 0);
    check_output("idle_holds_mode", bus.active_mode, 0);

    $display("[TB] extract from 4 elements");
    do_reset();
    load_n(4);
    send(3'd1, 4'd0, 8'd0);
    check_output("ext_copy_pulse", bus.ext_copy, 1);
    check_output("ext_heap_size", bus.heap_size, 3);
    check_output("ext_mode", bus.active_mode, 1);
    tick();
    check_output("ext_copy_cleared", bus.ext_copy, 0);
    check_output("ext_eng_start", bus.eng_start, 1);
    check_output("ext_mh_root", bus.mh_root, 1);
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check_output("ext_done", bus.done, 1);
    tick();

    $display("[TB] insert into a full heap");
    do_reset();
    load_n(16);
    check_output("load_saturates", bus.heap_size, 15);
    send(3'd3, 4'd0, 8'h80);
    check_output("ins_full_err", bus.err, 1);
    check_output("ins_full_no_start", bus.eng_start, 0);
    check_output("ins_full_heap", bus.heap_size, 15);
    tick();
    check_output("ins_full_err_cleared", bus.err, 0);
    check_output("ins_full_still_no_start", bus.eng_start, 0);

    $display("[TB] increase-value and insert");
    do_reset();
    load_n(5);
    send(3'd2, 4'd6, 8'h11);
    check_output("inc_idx6_err", bus.err, 1);
    check_output("inc_idx6_heap", bus.heap_size, 5);
    send(3'd2, 4'd0, 8'h11);
    check_output("inc_idx0_err", bus.err, 1);
    send(3'd2, 4'd5, 8'h99);
    check_output("inc_err_cleared", bus.err, 0);
    check_output("inc_eng_start", bus.eng_start, 1);
    check_output("inc_iv_idx", bus.iv_idx, 5);
    check_output("inc_iv_val", bus.iv_val, 8'h99);
    check_output("inc_mode", bus.active_mode, 2);
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check_output("inc_done", bus.done, 1);
    tick();
    send(3'd3, 4'd0, 8'h42);
    check_output("ins_mode", bus.active_mode, 3);
    check_output("ins_heap_size", bus.heap_size, 6);
    check_output("ins_iv_idx", bus.iv_idx, 6);
    check_output("ins_iv_val", bus.iv_val, 8'h42);
    check_output("ins_eng_start", bus.eng_start, 1);
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check_output("ins_done", bus.done, 1);
    tick();
    send(3'd7, 4'd0, 8'd0);
    check_output("illegal_cmd_err", bus.err, 1);
    check_output("illegal_keeps_mode", bus.active_mode, 3);

    $display("[TB] write-out of 3 elements");
    do_reset();
    load_n(3);
    send(3'd4, 4'd0, 8'd0);
    check_output("wr_mode", bus.active_mode, 4);
    for (int i = 1; i <= 3; i++) begin
      check_output("wr_valid", bus.wr_valid, 1);
      check_output("wr_idx", bus.wr_idx, i);
      tick();
    end
    check_output("wr_valid_end", bus.wr_valid, 0);
    check_output("wr_done", bus.done, 1);
    tick();
    check_output("wr_idle_holds_mode", bus.active_mode, 4);

    $display("[TB] empty-heap boundaries");
    do_reset();
    send(3'd4, 4'd0, 8'd0);
    check_output("wr_empty_done", bus.done, 1);
    check_output("wr_empty_no_valid", bus.wr_valid, 0);
    tick();
    send(3'd1, 4'd0, 8'd0);
    check_output("ext_empty_err", bus.err, 1);
    check_output("ext_empty_no_copy", bus.ext_copy, 0);
    load_n(1);
    send(3'd0, 4'd0, 8'd0);
    check_output("build_small_done", bus.done, 1);
    check_output("build_small_no_start", bus.eng_start, 0);
    tick();

    $display("[TB] reset during MH_WAIT");
    do_reset();
    load_n(4);
    send(3'd0, 4'd0, 8'd0);
    check_output("mid_build_root", bus.mh_root, 2);
    tick();
    reset = 1'b1;
    tick();
    check_output("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check_output("mid_rst_eng_start", bus.eng_start, 0);
    check_output("mid_rst_heap", bus.heap_size, 0);
    reset = 1'b0;
    tick();
    check_output("post_rst_heap", bus.heap_size, 0);
    check_output("post_rst_mh_root", bus.mh_root, 0);
    check_output("post_rst_ready", bus.cmd_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
